// File: rtl/pipe_out_transmitter_pkg.sv
// Shared constants and helpers for the okPipeOut transmit path.
package pipe_out_transmitter_pkg;

    localparam logic [15:0] FILL_WORD_DEFAULT   = 16'hDEAD;
    localparam int          BLOCK_WORDS_DEFAULT = 512;

    // Host endpoint address bases used by this slice of the design.
    localparam logic [7:0]  PIPE_OUT_BASE_ADDR  = 8'hA0;
    localparam logic [7:0]  WIRE_OUT_BASE_ADDR  = 8'h20;

    // Prefetch buffer occupancy; only three legal values exist.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_out_transmitter_if.sv
// Source FIFO read port and okPipeOut endpoint signals.
interface pipe_out_transmitter_if #(
    parameter int COUNT_WIDTH = 11
);
    logic                   ep_read;
    logic [15:0]            ep_datain;
    logic [15:0]            src_data;
    logic                   src_valid;
    logic                   src_ready;
    logic [COUNT_WIDTH-1:0] src_count;

    // Environment side: host strobe and FIFO head.
    modport master (
        output ep_read, src_data, src_valid, src_count,
        input  ep_datain, src_ready
    );

    // Transmitter side.
    modport slave (
        input  ep_read, src_data, src_valid, src_count,
        output ep_datain, src_ready
    );
endinterface

// File: rtl/pipe_out_transmitter_prefetch.sv
// Two-entry prefetch buffer (head + spare) fed from a FWFT FIFO.
module pipe_out_prefetch
    import pipe_out_transmitter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    input  logic        consume,
    output logic        src_ready,
    output logic [15:0] head,
    output logic [1:0]  occ,
    output logic        empty,
    output logic        starve
);

    occ_e        occ_r;
    occ_e        occ_n_s;
    logic [15:0] head_r;
    logic [15:0] head_n_s;
    logic [15:0] spare_r;
    logic [15:0] spare_n_s;
    logic        load_s;
    logic        pop_s;

    assign src_ready = (occ_r != OCC_FULL);
    assign empty     = (occ_r == OCC_EMPTY);
    assign load_s    = src_valid & src_ready;
    assign pop_s     = consume & ~empty;
    // A consume that finds nothing buffered hands the host the fill word.
    assign starve    = consume & empty;
    assign head      = head_r;
    assign occ       = occ_r;

    // Buffer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r   <= OCC_EMPTY;
            head_r  <= 16'h0000;
            spare_r <= 16'h0000;
        end else begin
            occ_r   <= occ_n_s;
            head_r  <= head_n_s;
            spare_r <= spare_n_s;
        end
    end

    // Next buffer contents from the load/consume combination.
    always_comb begin
        occ_n_s   = occ_r;
        head_n_s  = head_r;
        spare_n_s = spare_r;
        case (occ_r)
            OCC_EMPTY: begin
                if (load_s) begin
                    head_n_s = src_data;
                    occ_n_s  = OCC_ONE;
                end else begin
                    occ_n_s  = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (load_s && pop_s) begin
                    head_n_s = src_data;
                end else if (load_s) begin
                    spare_n_s = src_data;
                    occ_n_s   = OCC_FULL;
                end else if (pop_s) begin
                    head_n_s = spare_r;
                    occ_n_s  = OCC_EMPTY;
                end else begin
                    occ_n_s  = OCC_ONE;
                end
            end
            OCC_FULL: begin
                if (pop_s) begin
                    head_n_s = spare_r;
                    occ_n_s  = OCC_ONE;
                end else begin
                    occ_n_s  = OCC_FULL;
                end
            end
            default: begin
                occ_n_s = OCC_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/pipe_out_transmitter.sv
// ti_clk transmit engine: prefetch into okPipeOut, block and underflow stats.
module pipe_out_transmitter
    import pipe_out_transmitter_pkg::*;
#(
    parameter int          COUNT_WIDTH = 11,
    parameter int          BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
    parameter logic [15:0] FILL_WORD   = FILL_WORD_DEFAULT
) (
    input  logic                  ti_clk,
    input  logic                  ti_rst,
    pipe_out_transmitter_if.slave bus,
    input  logic                  clear_stats,
    output logic [15:0]           tx_available,
    output logic                  underflow,
    output logic [15:0]           underflow_count,
    output logic                  block_done,
    output logic [15:0]           block_count
);

    localparam int               IDX_W    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    logic                   read_d_r;
    logic [IDX_W-1:0]       word_idx_r;
    logic [15:0]            tx_available_r;
    logic                   underflow_r;
    logic [15:0]            underflow_count_r;
    logic                   block_done_r;
    logic [15:0]            block_count_r;

    logic [15:0]            head_s;
    logic [1:0]             occ_s;
    logic                   empty_s;
    logic                   starve_s;
    logic                   src_ready_s;
    logic                   last_word_s;
    logic [COUNT_WIDTH-1:0] src_count_s;
    logic [31:0]            tx_sum_s;
    logic [15:0]            tx_next_s;

    pipe_out_prefetch u_prefetch (
        .clk       (ti_clk),
        .rst       (ti_rst),
        .src_data  (bus.src_data),
        .src_valid (bus.src_valid),
        .consume   (read_d_r),
        .src_ready (src_ready_s),
        .head      (head_s),
        .occ       (occ_s),
        .empty     (empty_s),
        .starve    (starve_s)
    );

    // Data is a register mux only, so ep_read never reaches ep_datain combinationally.
    assign bus.ep_datain = empty_s ? FILL_WORD : head_s;
    assign bus.src_ready = src_ready_s;

    assign src_count_s = bus.src_count;
    assign tx_sum_s    = 32'(src_count_s) + {30'd0, occ_s};
    assign tx_next_s   = (tx_sum_s > 32'h0000_FFFF) ? 16'hFFFF : tx_sum_s[15:0];
    assign last_word_s = read_d_r & (word_idx_r == LAST_IDX);

    assign tx_available    = tx_available_r;
    assign underflow       = underflow_r;
    assign underflow_count = underflow_count_r;
    assign block_done      = block_done_r;
    assign block_count     = block_count_r;

    // The word shown during the cycle after a read strobe is the one consumed.
    always_ff @(posedge ti_clk or posedge ti_rst) begin
        if (ti_rst) begin
            read_d_r <= 1'b0;
        end else begin
            read_d_r <= bus.ep_read;
        end
    end

    // Word position within the current host block; counts starved reads too.
    always_ff @(posedge ti_clk or posedge ti_rst) begin
        if (ti_rst) begin
            word_idx_r <= '0;
        end else if (last_word_s) begin
            word_idx_r <= '0;
        end else if (read_d_r) begin
            word_idx_r <= word_idx_r + IDX_W'(1);
        end else begin
            word_idx_r <= word_idx_r;
        end
    end

    // Block completion pulse and wrapping block counter.
    always_ff @(posedge ti_clk or posedge ti_rst) begin
        if (ti_rst) begin
            block_done_r  <= 1'b0;
            block_count_r <= 16'h0000;
        end else begin
            block_done_r <= last_word_s;
            if (clear_stats) begin
                block_count_r <= 16'h0000;
            end else if (last_word_s) begin
                block_count_r <= block_count_r + 16'd1;
            end else begin
                block_count_r <= block_count_r;
            end
        end
    end

    // Sticky starvation flag and saturating starved-read counter.
    always_ff @(posedge ti_clk or posedge ti_rst) begin
        if (ti_rst) begin
            underflow_r       <= 1'b0;
            underflow_count_r <= 16'h0000;
        end else if (clear_stats) begin
            underflow_r       <= 1'b0;
            underflow_count_r <= 16'h0000;
        end else if (starve_s) begin
            underflow_r       <= 1'b1;
            underflow_count_r <= sat_inc16(underflow_count_r);
        end else begin
            underflow_r       <= underflow_r;
            underflow_count_r <= underflow_count_r;
        end
    end

    // Words obtainable by the host: FIFO occupancy plus prefetched words.
    always_ff @(posedge ti_clk or posedge ti_rst) begin
        if (ti_rst) begin
            tx_available_r <= 16'h0000;
        end else begin
            tx_available_r <= tx_next_s;
        end
    end

endmodule

// File: tb/tb_pipe_out_transmitter.sv
// Directed bench with a FIFO model, buffer-occupancy model and data scoreboard.
module tb_pipe_out_transmitter;

    localparam int          BW   = 4;
    localparam logic [15:0] FILL = 16'hDEAD;

    logic        ti_clk = 1'b0;
    logic        ti_rst = 1'b0;
    logic        clear_stats = 1'b0;
    logic [15:0] tx_available;
    logic        underflow;
    logic [15:0] underflow_count;
    logic        block_done;
    logic [15:0] block_count;

    pipe_out_transmitter_if #(.COUNT_WIDTH(11)) bus ();

    pipe_out_transmitter #(
        .COUNT_WIDTH (11),
        .BLOCK_WORDS (BW),
        .FILL_WORD   (FILL)
    ) dut (
        .ti_clk          (ti_clk),
        .ti_rst          (ti_rst),
        .bus             (bus),
        .clear_stats     (clear_stats),
        .tx_available    (tx_available),
        .underflow       (underflow),
        .underflow_count (underflow_count),
        .block_done      (block_done),
        .block_count     (block_count)
    );

    always #5 ti_clk = ~ti_clk;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          occ_m = 0;
    logic        rd_pend = 1'b0;
    logic        gate = 1'b1;
    int          idx_m = 0;
    logic [15:0] cnt_m = 16'h0000;
    logic [15:0] blocks_m = 16'h0000;
    logic        uf_m = 1'b0;
    logic        done_m = 1'b0;
    logic [15:0] tx_m = 16'h0000;
    int          starved_m = 0;
    int          done_pulses = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        bus.src_valid = gate && (fifo_q.size() > 0);
        bus.src_data  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
        bus.src_count = 11'(fifo_q.size());
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_tx"},   32'(tx_available),    32'(tx_m));
        check({tag, "_uf"},   32'(underflow),       32'(uf_m));
        check({tag, "_ucnt"}, 32'(underflow_count), 32'(cnt_m));
        check({tag, "_blk"},  32'(block_count),     32'(blocks_m));
    endtask

    // Return model to its reset state, dropping prefetched words from the scoreboard.
    task automatic model_reset();
        for (int i = 0; i < occ_m; i++) begin
            void'(exp_q.pop_front());
        end
        occ_m    = 0;
        rd_pend  = 1'b0;
        idx_m    = 0;
        cnt_m    = 16'h0000;
        blocks_m = 16'h0000;
        uf_m     = 1'b0;
        tx_m     = 16'h0000;
    endtask

    task automatic do_reset();
        bus.ep_read = 1'b0;
        ti_rst = 1'b1;
        @(posedge ti_clk);
        #1;
        model_reset();
        ti_rst = 1'b0;
        check("rst_data", 32'(bus.ep_datain), 32'(FILL));
        check_stats("rst");
    endtask

    // One clock: observe the host-visible word, advance the models, compare.
    task automatic tick();
        logic        pop;
        logic        cons;
        logic        clr;
        logic [15:0] seen;
        int          sum;
        pop  = bus.src_valid && bus.src_ready;
        cons = rd_pend;
        clr  = clear_stats;
        seen = bus.ep_datain;
        sum  = fifo_q.size() + occ_m;
        @(posedge ti_clk);
        rd_pend = bus.ep_read;
        #1;
        done_m = 1'b0;
        if (cons) begin
            if (occ_m == 0) begin
                check("starve_data", 32'(seen), 32'(FILL));
                uf_m = 1'b1;
                starved_m++;
                if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            end else begin
                check("data", 32'(seen), 32'(exp_q.pop_front()));
                occ_m--;
            end
            if (idx_m == BW - 1) begin
                idx_m = 0;
                done_m = 1'b1;
                blocks_m = blocks_m + 16'd1;
            end else begin
                idx_m++;
            end
        end
        if (pop) begin
            void'(fifo_q.pop_front());
            occ_m++;
        end
        if (clr) begin
            uf_m = 1'b0;
            cnt_m = 16'h0000;
            blocks_m = 16'h0000;
        end
        tx_m = (sum > 65535) ? 16'hFFFF : 16'(sum);
        if (done_m) done_pulses++;
        check("block_done", 32'(block_done), 32'(done_m));
        drive_src();
    endtask

    initial begin
        int ucnt_before;
        int starved_before;
        bus.ep_read = 1'b0;
        drive_src();

        // Asynchronous reset assertion, observed before any clock edge.
        #1 ti_rst = 1'b1;
        #1;
        check("init_data",   32'(bus.ep_datain), 32'(FILL));
        check("init_ready",  32'(bus.src_ready), 32'd1);
        check("init_tx",     32'(tx_available),  32'd0);
        check("init_done",   32'(block_done),    32'd0);
        check("init_ucnt",   32'(underflow_count), 32'd0);
        do_reset();

        // Prefetch fills, then four bubble-free reads.
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        drive_src();
        repeat (3) tick();
        check("fill_ready", 32'(bus.src_ready), 32'd0);
        check("fill_tx",    32'(tx_available),  32'd4);
        bus.ep_read = 1'b1;
        repeat (4) tick();
        bus.ep_read = 1'b0;
        repeat (2) tick();
        check_stats("burst");

        // Single read on empty buffer.
        bus.ep_read = 1'b1;
        tick();
        bus.ep_read = 1'b0;
        repeat (2) tick();
        check("empty_uf",   32'(underflow),       32'd1);
        check("empty_ucnt", 32'(underflow_count), 32'd1);
        check("empty_rdy",  32'(bus.src_ready),   32'd1);
        check_stats("empty");

        // Two whole blocks of BW words.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i));
        drive_src();
        done_pulses = 0;
        bus.ep_read = 1'b1;
        repeat (8) tick();
        bus.ep_read = 1'b0;
        repeat (2) tick();
        check("blk_pulses", 32'(done_pulses), 32'd2);
        check("blk_count",  32'(block_count), 32'd2);
        check("blk_uf",     32'(underflow),   32'd0);
        check_stats("blocks");

        // Continuous reads while the FIFO valid toggles every cycle.
        for (int i = 0; i < 12; i++) push_word(16'h0200 + 16'(i));
        ucnt_before = int'(underflow_count);
        starved_before = starved_m;
        bus.ep_read = 1'b1;
        for (int i = 0; i < 30; i++) begin
            gate = ~gate;
            drive_src();
            tick();
        end
        bus.ep_read = 1'b0;
        gate = 1'b1;
        drive_src();
        repeat (3) tick();
        check("tog_ucnt", 32'(underflow_count), 32'(ucnt_before + (starved_m - starved_before)));
        check("tog_drained", 32'(exp_q.size()), 32'd0);
        check_stats("toggle");

        // Starved reads until the counter saturates, then one more.
        bus.ep_read = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (cnt_m == 16'hFFFF) break;
            tick();
        end
        tick();
        check("sat_ucnt", 32'(underflow_count), 32'h0000_FFFF);
        check_stats("sat");

        // Clear coincident with a starved read: clear wins.
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("clr_ucnt", 32'(underflow_count), 32'd0);
        check("clr_uf",   32'(underflow),       32'd0);
        bus.ep_read = 1'b0;
        repeat (2) tick();

        // Reset mid-stream with a full buffer and a pending consume.
        for (int i = 0; i < 6; i++) push_word(16'h0300 + 16'(i));
        drive_src();
        repeat (3) tick();
        check("mid_full", 32'(bus.src_ready), 32'd0);
        bus.ep_read = 1'b1;
        tick();
        #2;
        bus.ep_read = 1'b0;
        ti_rst = 1'b1;
        #1;
        check("mid_data",  32'(bus.ep_datain), 32'(FILL));
        check("mid_ready", 32'(bus.src_ready), 32'd1);
        check("mid_tx",    32'(tx_available),  32'd0);
        model_reset();
        #1 ti_rst = 1'b0;
        tick();
        check("mid_head", 32'(bus.ep_datain), 32'h0000_0302);
        bus.ep_read = 1'b1;
        repeat (2) tick();
        bus.ep_read = 1'b0;
        repeat (2) tick();
        check("mid_uf", 32'(underflow), 32'd0);
        check_stats("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
